// File: rtl/wave_ch_regs.sv
// Wave channel register block: CPU window, length counter, trigger pulse, channel-active status.
// Latency: writes visible one cycle after the strobe edge; rdata is combinational from addr.
// Backpressure: none; every write and len_tick is accepted on the edge it is sampled.
module wave_ch_regs #(
    parameter int unsigned FREQ_W = 11,
    parameter int unsigned LEN_W  = 8,
    parameter int unsigned VOL_W  = 2
) (
    input  logic              apu_clk,
    input  logic              napu_reset,
    input  logic              apu_en,
    input  logic [2:0]        addr,
    input  logic              apu_wr,
    input  logic [7:0]        wdata,
    output logic [7:0]        rdata,
    input  logic              len_tick,
    output logic              dac_en,
    output logic [VOL_W-1:0]  vol,
    output logic [FREQ_W-1:0] freq,
    output logic              len_en,
    output logic              trig,
    output logic              ch_active
);

    localparam int unsigned LR_W = LEN_W + 1;
    localparam logic [LR_W-1:0] LEN_FULL = {1'b1, {LEN_W{1'b0}}};

    logic              dac_en_q,    dac_en_d;
    logic [VOL_W-1:0]  vol_q,       vol_d;
    logic [FREQ_W-1:0] freq_q,      freq_d;
    logic              len_en_q,    len_en_d;
    logic              trig_q,      trig_d;
    logic              ch_active_q, ch_active_d;
    logic [LR_W-1:0]   len_rem_q,   len_rem_d;

    logic wr_nr1;
    logic trig_wr;
    logic len_dec;

    // A length write or a trigger on the same edge as len_tick suppresses the decrement.
    assign wr_nr1  = apu_wr && (addr == 3'd1);
    assign trig_wr = apu_wr && (addr == 3'd4) && wdata[7];
    assign len_dec = len_tick && len_en_q && (len_rem_q != '0) && !wr_nr1 && !trig_wr;

    always_comb begin
        dac_en_d    = dac_en_q;
        vol_d       = vol_q;
        freq_d      = freq_q;
        len_en_d    = len_en_q;
        trig_d      = 1'b0;
        ch_active_d = ch_active_q;
        len_rem_d   = len_rem_q;

        if (!apu_en) begin
            dac_en_d    = 1'b0;
            vol_d       = '0;
            freq_d      = '0;
            len_en_d    = 1'b0;
            ch_active_d = 1'b0;
            len_rem_d   = '0;
        end else begin
            if (apu_wr) begin
                case (addr)
                    3'd0: begin
                        dac_en_d = wdata[7];
                        if (!wdata[7]) begin
                            ch_active_d = 1'b0;
                        end
                    end
                    3'd1: len_rem_d = LEN_FULL - {1'b0, wdata[LEN_W-1:0]};
                    3'd2: vol_d = wdata[4+VOL_W:5];
                    3'd3: freq_d[7:0] = wdata;
                    3'd4: begin
                        freq_d[FREQ_W-1:8] = wdata[FREQ_W-9:0];
                        len_en_d           = wdata[6];
                        if (wdata[7]) begin
                            trig_d      = 1'b1;
                            ch_active_d = dac_en_q;
                            if (len_rem_q == '0) begin
                                len_rem_d = LEN_FULL;
                            end
                        end
                    end
                    default: ;
                endcase
            end
            if (len_dec) begin
                len_rem_d = len_rem_q - LR_W'(1);
                if (len_rem_q == LR_W'(1)) begin
                    ch_active_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge apu_clk or negedge napu_reset) begin
        if (!napu_reset) begin
            dac_en_q    <= 1'b0;
            vol_q       <= '0;
            freq_q      <= '0;
            len_en_q    <= 1'b0;
            trig_q      <= 1'b0;
            ch_active_q <= 1'b0;
            len_rem_q   <= '0;
        end else begin
            dac_en_q    <= dac_en_d;
            vol_q       <= vol_d;
            freq_q      <= freq_d;
            len_en_q    <= len_en_d;
            trig_q      <= trig_d;
            ch_active_q <= ch_active_d;
            len_rem_q   <= len_rem_d;
        end
    end

    // Write-only and unused bits read back as 1.
    always_comb begin
        rdata = 8'hFF;
        case (addr)
            3'd0: rdata = {dac_en_q, 7'h7F};
            3'd2: rdata[4+VOL_W:5] = vol_q;
            3'd4: rdata = {1'b1, len_en_q, 6'h3F};
            default: ;
        endcase
    end

    assign dac_en    = dac_en_q;
    assign vol       = vol_q;
    assign freq      = freq_q;
    assign len_en    = len_en_q;
    assign trig      = trig_q;
    assign ch_active = ch_active_q;

endmodule

// File: tb/tb_wave_ch_regs.sv
// Bench for wave_ch_regs: two instances (default and wide/short-length) share one stimulus
// stream and are checked each cycle against an arithmetic model, plus directed literal checks.
module tb_wave_ch_regs;

    logic       apu_clk = 1'b0;
    logic       napu_reset = 1'b0;
    logic       apu_en = 1'b0;
    logic [2:0] addr = 3'd0;
    logic       apu_wr = 1'b0;
    logic [7:0] wdata = 8'd0;
    logic       len_tick = 1'b0;

    logic [7:0]  rdata0, rdata1;
    logic        dac_en0, dac_en1, len_en0, len_en1, trig0, trig1, act0, act1;
    logic [1:0]  vol0;
    logic [2:0]  vol1;
    logic [10:0] freq0;
    logic [13:0] freq1;

    int tests = 0;
    int fails = 0;

    always #5 apu_clk = ~apu_clk;

    wave_ch_regs dut0 (
        .apu_clk(apu_clk), .napu_reset(napu_reset), .apu_en(apu_en), .addr(addr),
        .apu_wr(apu_wr), .wdata(wdata), .rdata(rdata0), .len_tick(len_tick),
        .dac_en(dac_en0), .vol(vol0), .freq(freq0), .len_en(len_en0),
        .trig(trig0), .ch_active(act0)
    );

    wave_ch_regs #(.FREQ_W(14), .LEN_W(6), .VOL_W(3)) dut1 (
        .apu_clk(apu_clk), .napu_reset(napu_reset), .apu_en(apu_en), .addr(addr),
        .apu_wr(apu_wr), .wdata(wdata), .rdata(rdata1), .len_tick(len_tick),
        .dac_en(dac_en1), .vol(vol1), .freq(freq1), .len_en(len_en1),
        .trig(trig1), .ch_active(act1)
    );

    // Reference model: plain integers per instance
    int fw[2] = '{11, 14};
    int lw[2] = '{8, 6};
    int vw[2] = '{2, 3};
    int m_dac[2], m_vol[2], m_freq[2], m_len_en[2], m_trig[2], m_act[2], m_rem[2];

    always @(posedge apu_clk or negedge napu_reset) begin
        for (int i = 0; i < 2; i++) begin
            if (!napu_reset || !apu_en) begin
                m_dac[i] = 0; m_vol[i] = 0; m_freq[i] = 0; m_len_en[i] = 0;
                m_trig[i] = 0; m_act[i] = 0; m_rem[i] = 0;
            end else begin
                int  full;
                bit  blocked, do_dec;
                int  old_dac;
                full    = 1 << lw[i];
                old_dac = m_dac[i];
                blocked = apu_wr && (addr == 1 || (addr == 4 && wdata[7]));
                do_dec  = len_tick && (m_len_en[i] != 0) && (m_rem[i] != 0) && !blocked;
                m_trig[i] = 0;
                if (apu_wr) begin
                    case (addr)
                        0: begin
                            m_dac[i] = wdata[7];
                            if (!wdata[7]) m_act[i] = 0;
                        end
                        1: m_rem[i] = full - (int'(wdata) % full);
                        2: m_vol[i] = (int'(wdata) >> 5) % (1 << vw[i]);
                        3: m_freq[i] = (m_freq[i] & ~32'hFF) | int'(wdata);
                        4: begin
                            m_freq[i] = (m_freq[i] & 32'hFF)
                                      | ((int'(wdata) % (1 << (fw[i] - 8))) << 8);
                            m_len_en[i] = wdata[6];
                            if (wdata[7]) begin
                                m_trig[i] = 1;
                                m_act[i]  = old_dac;
                                if (m_rem[i] == 0) m_rem[i] = full;
                            end
                        end
                        default: ;
                    endcase
                end
                if (do_dec) begin
                    m_rem[i] = m_rem[i] - 1;
                    if (m_rem[i] == 0) m_act[i] = 0;
                end
            end
        end
    end

    function automatic int exp_rd(input int i, input int a);
        int fmask;
        case (a)
            0: return (m_dac[i] << 7) | 'h7F;
            2: begin
                fmask = ((1 << vw[i]) - 1) << 5;
                return ('hFF & ~fmask) | (m_vol[i] << 5);
            end
            4: return 'h80 | (m_len_en[i] << 6) | 'h3F;
            default: return 'hFF;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge apu_clk) begin
        chk("dac_en0", 32'(dac_en0), m_dac[0]);
        chk("vol0",    32'(vol0),    m_vol[0]);
        chk("freq0",   32'(freq0),   m_freq[0]);
        chk("len_en0", 32'(len_en0), m_len_en[0]);
        chk("trig0",   32'(trig0),   m_trig[0]);
        chk("active0", 32'(act0),    m_act[0]);
        chk("rdata0",  32'(rdata0),  exp_rd(0, int'(addr)));
        chk("dac_en1", 32'(dac_en1), m_dac[1]);
        chk("vol1",    32'(vol1),    m_vol[1]);
        chk("freq1",   32'(freq1),   m_freq[1]);
        chk("len_en1", 32'(len_en1), m_len_en[1]);
        chk("trig1",   32'(trig1),   m_trig[1]);
        chk("active1", 32'(act1),    m_act[1]);
        chk("rdata1",  32'(rdata1),  exp_rd(1, int'(addr)));
    end

    // Inputs change 2 time units after a rising edge and are sampled on the next one.
    task automatic cyc(input logic w, input logic [2:0] a, input logic [7:0] d, input logic t);
        @(posedge apu_clk);
        #2;
        apu_wr = w; addr = a; wdata = d; len_tick = t;
    endtask

    initial begin
        logic       w, t;
        logic [2:0] a;
        logic [7:0] d;

        // Reset state
        repeat (2) cyc(0, 0, 8'h00, 0);
        #1;
        chk("t1_rd0", 32'(rdata0), 32'h7F);
        chk("t1_out0", 32'({dac_en0, vol0, freq0, len_en0, trig0, act0}), 0);
        cyc(0, 4, 8'h00, 0);
        #1;
        chk("t1_rd4", 32'(rdata0), 32'hBF);
        napu_reset = 1'b1;
        apu_en     = 1'b1;

        // Trigger and length expiry
        cyc(1, 0, 8'h80, 0);
        cyc(1, 1, 8'hFE, 0);
        cyc(1, 4, 8'hC0, 0);
        cyc(0, 0, 8'h00, 0);
        chk("t2_trig", 32'(trig0), 1);
        chk("t2_act", 32'(act0), 1);
        chk("t2_act1", 32'(act1), 1);
        cyc(0, 0, 8'h00, 0);
        chk("t2_trig_off", 32'(trig0), 0);
        cyc(0, 0, 8'h00, 1);
        cyc(0, 0, 8'h00, 0);
        chk("t2_tick1_act", 32'(act0), 1);
        cyc(0, 0, 8'h00, 1);
        cyc(0, 0, 8'h00, 0);
        chk("t2_tick2_act", 32'(act0), 0);
        chk("t2_tick2_act1", 32'(act1), 0);

        // Reload from zero, ticks ignored with len_en clear
        cyc(1, 4, 8'h80, 0);
        cyc(0, 4, 8'h00, 1);
        #1;
        chk("t3_act", 32'(act0), 1);
        chk("t3_rd4", 32'(rdata0), 32'hBF);
        repeat (3) cyc(0, 4, 8'h00, 1);
        cyc(0, 0, 8'h00, 0);
        chk("t3_hold_act", 32'(act0), 1);

        // DAC off clears the channel; trigger still pulses
        cyc(1, 0, 8'h00, 0);
        cyc(0, 0, 8'h00, 0);
        #1;
        chk("t4_act", 32'(act0), 0);
        chk("t4_rd0", 32'(rdata0), 32'h7F);
        cyc(1, 4, 8'h80, 0);
        cyc(0, 0, 8'h00, 0);
        chk("t4_trig", 32'(trig0), 1);
        chk("t4_act_stay", 32'(act0), 0);

        // Length write collides with a tick: full reload, then 256 ticks to expire
        cyc(1, 0, 8'h80, 0);
        cyc(1, 4, 8'hC0, 0);
        cyc(1, 1, 8'h00, 1);
        repeat (255) cyc(0, 0, 8'h00, 1);
        cyc(0, 0, 8'h00, 0);
        chk("t5_act_255", 32'(act0), 1);
        cyc(0, 0, 8'h00, 1);
        cyc(0, 0, 8'h00, 0);
        chk("t5_act_256", 32'(act0), 0);

        // Back-to-back triggers
        cyc(1, 4, 8'h80, 0);
        cyc(1, 4, 8'h80, 0);
        chk("b2b_trig_a", 32'(trig0), 1);
        cyc(0, 0, 8'h00, 0);
        chk("b2b_trig_b", 32'(trig0), 1);
        cyc(0, 0, 8'h00, 0);
        chk("b2b_trig_end", 32'(trig0), 0);

        // Asynchronous reset in the middle of a trigger pulse
        cyc(1, 4, 8'h80, 0);
        cyc(0, 0, 8'h00, 0);
        chk("rst_trig_pre", 32'(trig0), 1);
        #1 napu_reset = 1'b0;
        #1;
        chk("rst_trig", 32'(trig0), 0);
        chk("rst_dac", 32'(dac_en0), 0);
        napu_reset = 1'b1;

        // Width parameters and master enable clear
        cyc(1, 3, 8'hA5, 0);
        cyc(1, 4, 8'h3F, 0);
        cyc(1, 2, 8'hE0, 0);
        cyc(0, 2, 8'h00, 0);
        #1;
        chk("t6_freq1", 32'(freq1), 32'h3FA5);
        chk("t6_vol1", 32'(vol1), 32'h7);
        chk("t6_freq0", 32'(freq0), 32'h7A5);
        chk("t6_vol0", 32'(vol0), 32'h3);
        chk("t6_rd2_1", 32'(rdata1), 32'hFF);
        cyc(1, 3, 8'hFF, 0);
        apu_en = 1'b0;
        cyc(0, 0, 8'h00, 0);
        chk("t6_clr_freq1", 32'(freq1), 0);
        chk("t6_clr_vol1", 32'(vol1), 0);
        apu_en = 1'b1;

        // Randomised traffic
        for (int n = 0; n < 3000; n++) begin
            w = ($urandom_range(0, 2) == 0);
            a = 3'($urandom_range(0, 7));
            d = 8'($urandom);
            if (a == 3'd4 && $urandom_range(0, 1) == 1) d[7] = 1'b1;
            if (a == 3'd1 && $urandom_range(0, 1) == 1) d = 8'hF0 | 8'($urandom_range(0, 15));
            if (a == 3'd0 && $urandom_range(0, 3) != 0) d[7] = 1'b1;
            t = ($urandom_range(0, 2) == 0);
            cyc(w, a, d, t);
            apu_en = ($urandom_range(0, 99) != 0);
            if (n % 700 == 350) begin
                #1 napu_reset = 1'b0;
                #1 napu_reset = 1'b1;
            end
        end
        cyc(0, 0, 8'h00, 0);
        @(negedge apu_clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
